// File: rtl/demux_tdm_4ch_if.sv
// Bus bundle for the four-lane TDM demultiplexer: serial sample input on one
// side, the four parallel lanes plus framing status on the other.
interface demux_tdm_4ch_if #(
  parameter int WIDTH = 1
);
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_sync;
  logic [WIDTH-1:0] out0;
  logic [WIDTH-1:0] out1;
  logic [WIDTH-1:0] out2;
  logic [WIDTH-1:0] out3;
  logic             out_valid;
  logic             locked;
  logic             sync_err;
  logic [1:0]       slot;

  // The sample source drives the serial side and observes the framed lanes.
  modport master (
    output in_data, in_valid, in_sync,
    input  out0, out1, out2, out3, out_valid, locked, sync_err, slot
  );

  // The demultiplexer consumes the serial side and drives the framed lanes.
  modport slave (
    input  in_data, in_valid, in_sync,
    output out0, out1, out2, out3, out_valid, locked, sync_err, slot
  );
endinterface

// File: rtl/demux_tdm_4ch.sv
// Four-lane time-division demultiplexer. Aligns to the slot-0 sync marker,
// stages slots 0..2 and publishes a whole frame at once when slot 3 arrives.
module demux_tdm_4ch #(
  parameter int WIDTH = 1
) (
  input  logic            clk,
  input  logic            reset_n,
  demux_tdm_4ch_if.slave  bus
);

  typedef enum logic {HUNT, LOCKED} state_t;

  state_t           state, state_nxt;
  logic [1:0]       slot, slot_nxt;
  logic [WIDTH-1:0] stage0, stage1, stage2;
  logic [WIDTH-1:0] stage0_nxt, stage1_nxt, stage2_nxt;
  logic [WIDTH-1:0] lane0, lane1, lane2, lane3;
  logic [WIDTH-1:0] lane0_nxt, lane1_nxt, lane2_nxt, lane3_nxt;
  logic             out_valid_q, out_valid_nxt;
  logic             sync_err_q, sync_err_nxt;
  logic             accept;
  logic             misaligned;

  assign accept     = bus.in_valid;
  assign misaligned = bus.in_sync && (slot != 2'd0);

  // Next-state logic: hunt for the marker, then steer each accepted sample
  // into its slot; the slot-3 sample goes straight to lane 3 so only three
  // staging registers are needed. A sync seen mid-frame restarts the frame.
  always_comb begin
    state_nxt     = state;
    slot_nxt      = slot;
    stage0_nxt    = stage0;
    stage1_nxt    = stage1;
    stage2_nxt    = stage2;
    lane0_nxt     = lane0;
    lane1_nxt     = lane1;
    lane2_nxt     = lane2;
    lane3_nxt     = lane3;
    out_valid_nxt = 1'b0;
    sync_err_nxt  = 1'b0;

    if (accept) begin
      case (state)
        HUNT: begin
          if (bus.in_sync) begin
            stage0_nxt = bus.in_data;
            slot_nxt   = 2'd1;
            state_nxt  = LOCKED;
          end
        end
        LOCKED: begin
          if (misaligned) begin
            sync_err_nxt = 1'b1;
            stage0_nxt   = bus.in_data;
            stage1_nxt   = '0;
            stage2_nxt   = '0;
            slot_nxt     = 2'd1;
          end else begin
            case (slot)
              2'd0: stage0_nxt = bus.in_data;
              2'd1: stage1_nxt = bus.in_data;
              2'd2: stage2_nxt = bus.in_data;
              default: begin
                lane0_nxt     = stage0;
                lane1_nxt     = stage1;
                lane2_nxt     = stage2;
                lane3_nxt     = bus.in_data;
                out_valid_nxt = 1'b1;
              end
            endcase
            slot_nxt = slot + 2'd1;
          end
        end
        default: state_nxt = HUNT;
      endcase
    end
  end

  // State, staging and lane registers; reset drops any partial frame.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= HUNT;
      slot        <= 2'd0;
      stage0      <= '0;
      stage1      <= '0;
      stage2      <= '0;
      lane0       <= '0;
      lane1       <= '0;
      lane2       <= '0;
      lane3       <= '0;
      out_valid_q <= 1'b0;
      sync_err_q  <= 1'b0;
    end else begin
      state       <= state_nxt;
      slot        <= slot_nxt;
      stage0      <= stage0_nxt;
      stage1      <= stage1_nxt;
      stage2      <= stage2_nxt;
      lane0       <= lane0_nxt;
      lane1       <= lane1_nxt;
      lane2       <= lane2_nxt;
      lane3       <= lane3_nxt;
      out_valid_q <= out_valid_nxt;
      sync_err_q  <= sync_err_nxt;
    end
  end

  assign bus.out0      = lane0;
  assign bus.out1      = lane1;
  assign bus.out2      = lane2;
  assign bus.out3      = lane3;
  assign bus.out_valid = out_valid_q;
  assign bus.sync_err  = sync_err_q;
  assign bus.locked    = (state == LOCKED);
  assign bus.slot      = slot;

endmodule

// File: tb/tb_demux_tdm_4ch.sv
// Bench for the four-lane TDM demultiplexer: a vector table for the steady
// framing behaviour, plus hand-written reset, hunt and gap sequences.
module tb_demux_tdm_4ch;

  logic clk;
  logic reset_n;
  int   errors;
  int   checks;

  demux_tdm_4ch_if #(.WIDTH(8)) bus ();

  demux_tdm_4ch #(.WIDTH(8)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  typedef struct {
    logic        v;
    logic        s;
    logic [7:0]  d;
    logic        eov;
    logic        ese;
    logic        elk;
    logic [1:0]  eslot;
    logic [31:0] eouts;
  } vec_t;

  vec_t tbl[$];

  // Free-running 10-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic void addVec(input logic v, input logic s, input logic [7:0] d,
                                 input logic eov, input logic ese, input logic elk,
                                 input logic [1:0] eslot, input logic [31:0] eouts);
    vec_t r;
    r.v = v; r.s = s; r.d = d;
    r.eov = eov; r.ese = ese; r.elk = elk; r.eslot = eslot; r.eouts = eouts;
    tbl.push_back(r);
  endfunction

  task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic checkOutput(input string name, input logic eov, input logic ese,
                             input logic elk, input logic [1:0] eslot,
                             input logic [31:0] eouts);
    cmp({name, ".out_valid"}, {31'd0, bus.out_valid}, {31'd0, eov});
    cmp({name, ".sync_err"},  {31'd0, bus.sync_err},  {31'd0, ese});
    cmp({name, ".locked"},    {31'd0, bus.locked},    {31'd0, elk});
    cmp({name, ".slot"},      {30'd0, bus.slot},      {30'd0, eslot});
    cmp({name, ".lanes"}, {bus.out0, bus.out1, bus.out2, bus.out3}, eouts);
  endtask

  // Drive one cycle of input away from the active edge, then sample just
  // after the edge that consumed it.
  task automatic applyStimulus(input logic v, input logic s, input logic [7:0] d);
    @(negedge clk);
    bus.in_valid = v;
    bus.in_sync  = s;
    bus.in_data  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    @(negedge clk);
    reset_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_sync  = 1'b0;
    bus.in_data  = 8'h00;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    reset_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_sync  = 1'b0;
    bus.in_data  = 8'h00;

    // Basic frame
    addVec(1, 1, 8'h11, 0, 0, 1, 2'd1, 32'h0);
    addVec(1, 0, 8'h22, 0, 0, 1, 2'd2, 32'h0);
    addVec(1, 0, 8'h33, 0, 0, 1, 2'd3, 32'h0);
    addVec(1, 0, 8'h44, 1, 0, 1, 2'd0, 32'h11223344);
    addVec(0, 0, 8'hEE, 0, 0, 1, 2'd0, 32'h11223344);
    // Unsynced slot 0 accepted once locked, then misaligned sync
    addVec(1, 0, 8'h10, 0, 0, 1, 2'd1, 32'h11223344);
    addVec(1, 0, 8'h20, 0, 0, 1, 2'd2, 32'h11223344);
    addVec(1, 1, 8'h55, 0, 1, 1, 2'd1, 32'h11223344);
    addVec(1, 0, 8'h66, 0, 0, 1, 2'd2, 32'h11223344);
    addVec(1, 0, 8'h77, 0, 0, 1, 2'd3, 32'h11223344);
    addVec(1, 0, 8'h88, 1, 0, 1, 2'd0, 32'h55667788);
    // Back-to-back frames, sync only on the first
    addVec(1, 1, 8'hA0, 0, 0, 1, 2'd1, 32'h55667788);
    addVec(1, 0, 8'hA1, 0, 0, 1, 2'd2, 32'h55667788);
    addVec(1, 0, 8'hA2, 0, 0, 1, 2'd3, 32'h55667788);
    addVec(1, 0, 8'hA3, 1, 0, 1, 2'd0, 32'hA0A1A2A3);
    addVec(1, 0, 8'hB0, 0, 0, 1, 2'd1, 32'hA0A1A2A3);
    addVec(1, 0, 8'hB1, 0, 0, 1, 2'd2, 32'hA0A1A2A3);
    addVec(1, 0, 8'hB2, 0, 0, 1, 2'd3, 32'hA0A1A2A3);
    addVec(1, 0, 8'hB3, 1, 0, 1, 2'd0, 32'hB0B1B2B3);
    addVec(1, 0, 8'hC0, 0, 0, 1, 2'd1, 32'hB0B1B2B3);
    addVec(1, 0, 8'hC1, 0, 0, 1, 2'd2, 32'hB0B1B2B3);
    addVec(1, 0, 8'hC2, 0, 0, 1, 2'd3, 32'hB0B1B2B3);
    addVec(1, 0, 8'hC3, 1, 0, 1, 2'd0, 32'hC0C1C2C3);
    addVec(0, 0, 8'h00, 0, 0, 1, 2'd0, 32'hC0C1C2C3);

    #1;
    checkOutput("reset", 0, 0, 0, 2'd0, 32'h0);
    doReset();
    checkOutput("after_reset", 0, 0, 0, 2'd0, 32'h0);

    for (int i = 0; i < tbl.size(); i++) begin
      applyStimulus(tbl[i].v, tbl[i].s, tbl[i].d);
      checkOutput($sformatf("vec%0d", i), tbl[i].eov, tbl[i].ese, tbl[i].elk,
                  tbl[i].eslot, tbl[i].eouts);
    end

    // Reset mid-frame: clear takes effect between edges without a clock.
    applyStimulus(1, 0, 8'hD0);
    applyStimulus(1, 0, 8'hD1);
    checkOutput("midframe", 0, 0, 1, 2'd2, 32'hC0C1C2C3);
    @(negedge clk);
    bus.in_valid = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    checkOutput("async_clear", 0, 0, 0, 2'd0, 32'h0);
    #1 reset_n = 1'b1;

    // Hunt: unsynced samples and sync without valid are dropped.
    applyStimulus(1, 0, 8'hAA);
    checkOutput("hunt_aa", 0, 0, 0, 2'd0, 32'h0);
    applyStimulus(1, 0, 8'hBB);
    checkOutput("hunt_bb", 0, 0, 0, 2'd0, 32'h0);
    applyStimulus(0, 1, 8'hCC);
    checkOutput("hunt_novalid", 0, 0, 0, 2'd0, 32'h0);
    applyStimulus(1, 1, 8'h01);
    checkOutput("hunt_sync", 0, 0, 1, 2'd1, 32'h0);
    applyStimulus(1, 0, 8'h02);
    applyStimulus(1, 0, 8'h03);
    applyStimulus(1, 0, 8'h04);
    checkOutput("hunt_frame", 1, 0, 1, 2'd0, 32'h01020304);

    // Gapped frame: lanes hold the previous frame through the gap.
    applyStimulus(1, 1, 8'h11);
    applyStimulus(1, 0, 8'h22);
    for (int g = 0; g < 3; g++) begin
      applyStimulus(0, 0, 8'hFF);
      checkOutput($sformatf("gap%0d", g), 0, 0, 1, 2'd2, 32'h01020304);
    end
    applyStimulus(1, 0, 8'h33);
    checkOutput("gap_slot2", 0, 0, 1, 2'd3, 32'h01020304);
    applyStimulus(1, 0, 8'h44);
    checkOutput("gap_frame", 1, 0, 1, 2'd0, 32'h11223344);
    applyStimulus(0, 0, 8'h00);
    checkOutput("gap_idle", 0, 0, 1, 2'd0, 32'h11223344);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/demux_tdm_4ch.md
# demux_tdm_4ch

Four-lane time-division demultiplexer: the receive-side counterpart of the 4:1 mux in the mux block family. One sample stream carries slots 0-3 in round-robin order with a sync marker on slot 0. The block aligns to the marker, steers each sample to its lane and presents all four lanes together as one registered frame with a one-cycle valid strobe. It sits between the serial link and per-channel consumers.

## Interface
- WIDTH, 1, bit width of each sample and each output lane
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous, active-low reset
- in_data  input  WIDTH  incoming sample
- in_valid  input  1  in_data is a sample this cycle
- in_sync  input  1  qualified by in_valid; marks the sample as slot 0
- out0, out1, out2, out3  output  WIDTH each  lane registers; slots 0..3 of the last complete frame
- out_valid  output  1  one-cycle strobe: out0..out3 updated with a new frame
- locked  output  1  aligned to frame boundaries
- sync_err  output  1  one-cycle strobe: sync arrived mid-frame; partial frame discarded
- slot  output  2  slot index the next accepted sample will occupy

## Operation
- A sample is accepted on a rising clk edge where in_valid=1. in_sync with in_valid=0 is ignored.
- State HUNT (after reset): locked=0.
  - Accepted samples with in_sync=0 are dropped. slot stays 0.
  - An accepted sample with in_sync=1 is written to staging[0]. Then slot becomes 1, state becomes LOCKED, and locked=1.
- State LOCKED, normal sample (in_sync=0, or in_sync=1 with slot=0):
  - The sample is written to staging[slot], and slot increments modulo 4.
  - When the accepted sample is slot 3: staging[0..2] plus that sample load out0..out3 simultaneously, out_valid=1 for the next cycle, and slot wraps to 0.
- State LOCKED, in_sync=1 with slot≠0 (misalignment):
  - sync_err=1 for one cycle.
  - Staging contents are discarded, and out0..out3 are not updated.
  - The sample is taken as slot 0 of a new frame: staging[0] is loaded and slot becomes 1. State stays LOCKED.
- LOCKED, in_sync=0 while slot=0: the sample is accepted as slot 0. Sync is required only at lock acquisition and is checked thereafter.
- Outputs out0..out3 hold their value until the next complete frame. Staging registers are internal only.
- Gaps in in_valid of any length are allowed mid-frame. There is no timeout.
- Reset (any time, including mid-frame) gives:
  - State HUNT, slot=0.
  - Staging and out0..out3 cleared to 0.
  - out_valid, sync_err and locked all 0.
  - Any partial frame is lost.

## Timing
- All outputs are registered and change only on rising clk, except for asynchronous clear on reset_n low.
- Latency: the slot-3 sample is accepted at edge N. New out0..out3 values and out_valid=1 are visible after edge N. out_valid returns to 0 after edge N+1.
- Minimum spacing between out_valid pulses is 4 cycles, so out_valid is never high on consecutive cycles.
- sync_err is asserted for the cycle after the offending edge. out_valid and sync_err are never high together.
- slot and locked reflect state after each edge, so slot=0 whenever a frame has just completed.
- Full throughput: one sample per cycle with no back-pressure. The block never stalls the sender.
- After reset_n deasserts, the first edge may accept a sample.

## Test plan
- **Basic frame:** WIDTH=8; reset, then 4 consecutive valid samples 0x11(sync), 0x22, 0x33, 0x44 → after 4th edge: out0..3 = 0x11, 0x22, 0x33, 0x44; out_valid high exactly 1 cycle; slot=0; locked=1.
- **Hunt discard:** 0xAA, 0xBB with no sync, then a 4-sample frame starting with sync 0x01 → only 0x01..0x04 appear; locked stays 0 until the sync edge.
- **Gapped input:** same frame with in_valid low for 3 cycles between slots 1 and 2 → identical outputs; out_valid one cycle after the slot-3 edge; outputs hold the prior frame during the gap.
- **Misaligned sync:** locked; send slot 0, slot 1, then sync 0x55 → sync_err 1 cycle, no out_valid, slot=1; follow with 0x66, 0x77, 0x88 → out0..3 = 0x55..0x88.
- **Reset mid-frame:** after 2 samples of a frame, pulse reset_n low asynchronously between edges → all outputs 0 immediately; locked=0; samples without sync are dropped afterwards.
- **Back-to-back frames:** 3 frames of continuous valid (sync only on first) → out_valid pulses every 4 cycles with the correct lane data and no sync_err.
